// File: rtl/ibus_pkg.sv
// Shared ibus types: response payload and pipeline limits.
// Reused by the IFU-side bus mux.
package ibus_pkg;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } ibus_rsp_t;

    localparam int unsigned RSP_W       = $bits(ibus_rsp_t);
    localparam int unsigned LATENCY_MAX = 4;

endpackage

// File: rtl/ibus_rsp_fifo.sv
// First-word fall-through response FIFO; pointers carry an extra wrap bit
// so that full and empty can be told apart.
module ibus_rsp_fifo
    import ibus_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  ibus_rsp_t    i_data,
    input  logic         i_pop,
    output logic         o_valid,
    output ibus_rsp_t    o_data,
    output logic [PW:0]  o_count
);

    localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ibus_rsp_fifo: DEPTH must be a power of two >= 2");
    end

    ibus_rsp_t   r_mem [DEPTH];
    logic [PW:0] r_wptr;
    logic [PW:0] r_rptr;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_push  = i_push & ~w_full;
    assign w_pop   = i_pop & ~w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[PW-1:0]] <= i_data;
    end

    assign o_valid = ~w_empty;
    assign o_data  = r_mem[r_rptr[PW-1:0]];
    assign o_count = r_wptr - r_rptr;

endmodule

// File: rtl/ibus_mem_responder.sv
// Responder end of the ibus: word-addressed memory behind a fixed-latency read
// pipeline and a response FIFO, flow-controlled by a credit counter.
module ibus_mem_responder
    import ibus_pkg::*;
#(
    parameter int unsigned AW         = 10,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] ibus_addr_i,
    input  logic [31:0] ibus_data_i,
    input  logic [3:0]  ibus_sel_i,
    input  logic        ibus_we_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] ibus_data_o,
    output logic        rsp_err_o
);

    localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_lat
        $error("ibus_mem_responder: LATENCY must be in 1..4");
    end
    if (AW < 1 || AW > 29) begin : g_bad_aw
        $error("ibus_mem_responder: AW must be in 1..29");
    end

    logic [31:0]   r_mem [2**AW];
    logic [CW-1:0] r_cnt;
    logic [31:0]   w_off;
    logic [AW-1:0] w_idx;
    logic          w_in_win;
    logic          w_accept;
    logic          w_pop;
    logic          w_push;
    logic          w_head_vld;
    logic [CW-1:0] w_fifo_cnt;
    logic          w_unused_off;
    ibus_rsp_t     w_rsp;
    ibus_rsp_t     w_push_rsp;
    ibus_rsp_t     w_head;

    // Window offset wraps modulo 2**32, so addresses below BASE_ADDR fall outside.
    assign w_off        = ibus_addr_i - BASE_ADDR;
    assign w_in_win     = (w_off[31:AW+2] == '0);
    assign w_idx        = w_off[AW+1:2];
    assign w_unused_off = ^w_off[1:0];

    assign req_ready_o = ~rst & (r_cnt < CNT_MAX);
    assign w_accept    = req_valid_i & req_ready_o;
    assign w_pop       = w_head_vld & rsp_ready_i;

    always_comb begin
        w_rsp     = '0;
        w_rsp.err = ~w_in_win;
        if (w_in_win && !ibus_we_i) w_rsp.data = r_mem[w_idx];
    end

    always_ff @(posedge clk) begin
        if (w_accept && ibus_we_i && w_in_win) begin
            for (int b = 0; b < 4; b++) begin
                if (ibus_sel_i[b]) r_mem[w_idx][8*b +: 8] <= ibus_data_i[8*b +: 8];
            end
        end
    end

    if (LATENCY == 1) begin : g_lat1
        assign w_push     = w_accept;
        assign w_push_rsp = w_rsp;
    end else begin : g_pipe
        logic [LATENCY-2:0] r_vld;
        ibus_rsp_t          r_stg [LATENCY-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_vld <= '0;
                for (int i = 0; i < LATENCY - 1; i++) r_stg[i] <= '0;
            end else begin
                r_vld[0] <= w_accept;
                r_stg[0] <= w_rsp;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    r_vld[i] <= r_vld[i-1];
                    r_stg[i] <= r_stg[i-1];
                end
            end
        end

        assign w_push     = r_vld[LATENCY-2];
        assign w_push_rsp = r_stg[LATENCY-2];
    end

    // Credits cover pipeline plus FIFO, so a push always finds room.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept && !w_pop) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else if (!w_accept && w_pop) begin
            r_cnt <= r_cnt - CNT_ONE;
        end
    end

    ibus_rsp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_rsp),
        .i_pop   (w_pop),
        .o_valid (w_head_vld),
        .o_data  (w_head),
        .o_count (w_fifo_cnt)
    );

    assert property (@(posedge clk) disable iff (rst) w_fifo_cnt <= r_cnt);

    assign rsp_valid_o = w_head_vld;
    assign ibus_data_o = w_head_vld ? w_head.data : 32'h0;
    assign rsp_err_o   = w_head_vld & w_head.err;

endmodule

// File: tb/tb_ibus_mem_responder.sv
// Randomized bench for ibus_mem_responder against a queue/array reference model.
module tb_ibus_mem_responder;

    localparam int unsigned AW   = 10;
    localparam int unsigned LAT  = 2;
    localparam int unsigned FD   = 4;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] ibus_addr_i = '0;
    logic [31:0] ibus_data_i = '0;
    logic [3:0]  ibus_sel_i = '0;
    logic        ibus_we_i = 1'b0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] ibus_data_o;
    logic        rsp_err_o;

    always #5 clk = ~clk;

    ibus_mem_responder #(
        .AW         (AW),
        .LATENCY    (LAT),
        .FIFO_DEPTH (FD),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .ibus_addr_i (ibus_addr_i),
        .ibus_data_i (ibus_data_i),
        .ibus_sel_i  (ibus_sel_i),
        .ibus_we_i   (ibus_we_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .ibus_data_o (ibus_data_o),
        .rsp_err_o   (rsp_err_o)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          vis;   // edge count after which the response is visible
    } exp_rsp_t;

    exp_rsp_t    q[$];
    logic [31:0] mem_m [16];
    int          n_edge = 0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic bit exp_valid();
        return (q.size() > 0) && (n_edge >= q[0].vis);
    endfunction

    task automatic check_outputs();
        bit ev;
        ev = exp_valid();
        chk("req_ready", {31'b0, req_ready_o}, {31'b0, (q.size() < FD)});
        chk("rsp_valid", {31'b0, rsp_valid_o}, {31'b0, ev});
        chk("rsp_data", ibus_data_o, ev ? q[0].data : 32'h0);
        chk("rsp_err", {31'b0, rsp_err_o}, ev ? {31'b0, q[0].err} : 32'h0);
    endtask

    // One clock: model the edge from the currently driven inputs, then check at negedge.
    task automatic step(output bit acc);
        bit          pop;
        logic [31:0] off;
        logic [31:0] rd;
        bit          inwin;
        int          idx;
        acc = req_valid_i && (q.size() < FD);
        pop = rsp_ready_i && exp_valid();
        @(posedge clk);
        n_edge++;
        if (pop) q.delete(0);
        if (acc) begin
            off   = ibus_addr_i - BASE;
            inwin = ((off >> 2) < (32'd1 << AW));
            idx   = int'(off >> 2);
            rd    = 32'h0;
            if (inwin && idx < 16) begin
                if (!ibus_we_i) rd = mem_m[idx];
                else for (int b = 0; b < 4; b++)
                    if (ibus_sel_i[b]) mem_m[idx][8*b +: 8] = ibus_data_i[8*b +: 8];
            end
            q.push_back('{data: rd, err: !inwin, vis: n_edge + int'(LAT) - 1});
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        bit acc;
        req_valid_i = 1'b0;
        for (int k = 0; k < n; k++) step(acc);
    endtask

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] sel);
        bit acc;
        acc         = 1'b0;
        req_valid_i = 1'b1;
        ibus_we_i   = we;
        ibus_addr_i = addr;
        ibus_data_i = data;
        ibus_sel_i  = sel;
        for (int k = 0; k < 20 && !acc; k++) step(acc);
        chk("send_accepted", {31'b0, acc}, 32'h1);
        req_valid_i = 1'b0;
    endtask

    task automatic drain();
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b0;
        for (int k = 0; k < 20 && q.size() > 0; k++) idle(1);
    endtask

    task automatic do_reset(input string tag);
        #1 rst = 1'b1;
        #1;
        chk({tag, "_rst_valid"}, {31'b0, rsp_valid_o}, 32'h0);
        chk({tag, "_rst_data"}, ibus_data_o, 32'h0);
        chk({tag, "_rst_err"}, {31'b0, rsp_err_o}, 32'h0);
        chk({tag, "_rst_ready"}, {31'b0, req_ready_o}, 32'h0);
        q.delete();
        req_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk({tag, "_rel_ready"}, {31'b0, req_ready_o}, 32'h1);
    endtask

    function automatic logic [31:0] rand_addr(input bit allow_oow);
        logic [31:0] a;
        int          r;
        r = $urandom_range(0, 9);
        a = BASE + 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
        if (allow_oow && r == 0) a = BASE + (32'd1 << (AW + 2)) + 32'($urandom_range(0, 15)) * 32'd4;
        else if (allow_oow && r == 1) a = BASE - 32'd4;
        return a;
    endfunction

    initial begin
        bit   acc;
        int   n_acc;
        bit   all_ready;
        int   idx;

        #2;
        chk("reset_ready", {31'b0, req_ready_o}, 32'h0);
        chk("reset_valid", {31'b0, rsp_valid_o}, 32'h0);
        chk("reset_data", ibus_data_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Preload the model-tracked words.
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(1'b1, BASE + 32'(i) * 4, (i == 0) ? 32'h0000_0013 :
                 (i == 4) ? 32'h1122_3344 : $urandom, 4'hF);
        end
        drain();

        // Reset release then a first read of word 0.
        do_reset("t1");
        rsp_ready_i = 1'b0;
        send(1'b0, BASE, 32'h0, 4'h0);
        idle(1);
        chk("t1_valid", {31'b0, rsp_valid_o}, 32'h1);
        chk("t1_data", ibus_data_o, 32'h0000_0013);
        drain();

        // Byte-masked write followed immediately by a read.
        rsp_ready_i = 1'b0;
        send(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'b0101);
        send(1'b0, BASE + 32'h10, 32'h0, 4'h0);
        rsp_ready_i = 1'b1;
        idle(1);
        rsp_ready_i = 1'b0;
        chk("t2_merge", ibus_data_o, 32'h11AD_33EF);
        drain();

        // Back-pressure: stream reads with rsp_ready_i low.
        rsp_ready_i = 1'b0;
        n_acc       = 0;
        idx         = 0;
        for (int k = 0; k < 8; k++) begin
            req_valid_i = 1'b1;
            ibus_we_i   = 1'b0;
            ibus_addr_i = BASE + 32'(idx) * 4;
            step(acc);
            if (acc) begin
                n_acc++;
                idx++;
            end
        end
        chk("t3_accepted", 32'(n_acc), 32'(FD));
        chk("t3_ready_low", {31'b0, req_ready_o}, 32'h0);
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        idle(1);
        rsp_ready_i = 1'b0;
        chk("t3_ready_back", {31'b0, req_ready_o}, 32'h1);
        drain();

        // Full throughput: back-to-back reads with rsp_ready_i high.
        rsp_ready_i = 1'b1;
        all_ready   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req_valid_i = 1'b1;
            ibus_we_i   = 1'b0;
            ibus_addr_i = BASE + 32'(k % 3) * 4;
            all_ready   = all_ready & req_ready_o;
            step(acc);
        end
        all_ready = all_ready & req_ready_o;
        chk("t4_ready_held", {31'b0, all_ready}, 32'h1);
        drain();

        // Out-of-window read and write.
        rsp_ready_i = 1'b0;
        send(1'b0, BASE + (32'd1 << (AW + 2)), 32'h0, 4'h0);
        idle(1);
        chk("t5_err", {31'b0, rsp_err_o}, 32'h1);
        chk("t5_data", ibus_data_o, 32'h0);
        drain();
        send(1'b1, BASE + (32'd1 << (AW + 2)), 32'hFFFF_FFFF, 4'hF);
        send(1'b0, BASE, 32'h0, 4'h0);
        drain();

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            req_valid_i = ($urandom_range(0, 9) < 7);
            ibus_we_i   = ($urandom_range(0, 9) < 3);
            ibus_addr_i = rand_addr(1'b1);
            ibus_data_i = $urandom;
            ibus_sel_i  = 4'($urandom_range(0, 15));
            rsp_ready_i = ($urandom_range(0, 9) < 6);
            step(acc);
        end
        drain();

        // Reset with three responses queued and one in the pipeline.
        rsp_ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) send(1'b0, BASE + 32'(i) * 4, 32'h0, 4'h0);
        do_reset("t6");
        rsp_ready_i = 1'b1;
        idle(6);
        for (int i = 0; i < 16; i++) send(1'b0, BASE + 32'(i) * 4, 32'h0, 4'h0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
